// File: rtl/mapped_memory_controller.sv
// Data memory with a memory-mapped peripheral window: display registers, a synchronised
// switch port with change detection, and a sticky access-error status register.
// Optional macro RAM_CLEAR_EN adds a post-reset engine that zeroes the RAM while busy is high.
module mapped_memory_controller #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned NUM_DISP     = 2,
    parameter int unsigned SWITCH_WIDTH = 18
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           ren,
    input  logic [ADDR_WIDTH-1:0]          radr,
    output logic [DATA_WIDTH-1:0]          rvalue,
    output logic                           rvalid,
    input  logic                           wenable,
    input  logic [ADDR_WIDTH-1:0]          wadr,
    input  logic [DATA_WIDTH-1:0]          wvalue,
    output logic                           busy,
    output logic [NUM_DISP*DATA_WIDTH-1:0] disp_values,
    input  logic [SWITCH_WIDTH-1:0]        switches,
    output logic                           access_error
);
    localparam int unsigned RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DISP_AW = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
    localparam logic [ADDR_WIDTH-1:0] RAM_TOP = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0] NDISP    = 4'(NUM_DISP);
    localparam logic [3:0] OFF_SW   = 4'd8;
    localparam logic [3:0] OFF_CHG  = 4'd9;
    localparam logic [3:0] OFF_STAT = 4'd10;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_disp [NUM_DISP];
    logic [SWITCH_WIDTH-1:0] r_sync1, r_sync2, r_sync_prev;
    logic                    r_flag, r_err, r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rvalue;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_busy, w_clr_we;
    logic [RAM_AW-1:0]       w_clr_adr;

    // MMIO_BASE = 2^ADDR_WIDTH - 16, so the window is exactly "upper address bits all ones"
    logic       w_rmmio, w_wmmio, w_rram, w_wram, w_rdisp, w_wdisp;
    logic       w_racc, w_wacc, w_rmapped, w_wmapped, w_change;
    logic [3:0] w_roff, w_woff;
    assign w_rmmio   = &radr[ADDR_WIDTH-1:4];
    assign w_wmmio   = &wadr[ADDR_WIDTH-1:4];
    assign w_roff    = radr[3:0];
    assign w_woff    = wadr[3:0];
    assign w_rram    = radr < RAM_TOP;
    assign w_wram    = wadr < RAM_TOP;
    assign w_rdisp   = w_rmmio && (w_roff < NDISP);
    assign w_wdisp   = w_wmmio && (w_woff < NDISP);
    assign w_racc    = ren && !w_busy;
    assign w_wacc    = wenable && !w_busy;
    assign w_rmapped = w_rram || w_rdisp ||
                       (w_rmmio && (w_roff == OFF_SW || w_roff == OFF_CHG || w_roff == OFF_STAT));
    assign w_wmapped = w_wram || w_wdisp ||
                       (w_wmmio && (w_woff == OFF_SW || w_woff == OFF_CHG || w_woff == OFF_STAT));
    assign w_change  = r_sync2 != r_sync_prev;

`ifdef RAM_CLEAR_EN
    typedef enum logic {StIdle, StClear} state_e;
    state_e            r_state, w_state_next;
    logic [RAM_AW-1:0] r_clr_adr, w_clr_adr_next;

    // Clear engine state; reset always restarts the sweep at address 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StClear;
            r_clr_adr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_adr <= w_clr_adr_next;
        end
    end

    // Sweep one word per cycle, leave CLEAR after the last word
    always_comb begin
        w_state_next   = r_state;
        w_clr_adr_next = r_clr_adr;
        w_clr_we       = 1'b0;
        case (r_state)
            StClear: begin
                w_clr_we = 1'b1;
                if (r_clr_adr == RAM_AW'(DEPTH - 1)) begin
                    w_state_next   = StIdle;
                    w_clr_adr_next = '0;
                end else begin
                    w_clr_adr_next = r_clr_adr + RAM_AW'(1);
                end
            end
            default: ;
        endcase
    end

    assign w_busy    = (r_state == StClear);
    assign w_clr_adr = r_clr_adr;
`else
    assign w_busy    = 1'b0;
    assign w_clr_we  = 1'b0;
    assign w_clr_adr = '0;
`endif

    // RAM array, not reset
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_adr] <= '0;
        end else if (w_wacc && w_wram) begin
            r_mem[wadr[RAM_AW-1:0]] <= wvalue;
        end
    end

    // Read mux with write-first forwarding for RAM and display registers
    always_comb begin
        w_rdata = '0;
        if (w_rram) begin
            w_rdata = (w_wacc && wadr == radr) ? wvalue : r_mem[radr[RAM_AW-1:0]];
        end else if (w_rdisp) begin
            w_rdata = (w_wacc && wadr == radr) ? wvalue : r_disp[w_roff[DISP_AW-1:0]];
        end else if (w_rmmio) begin
            case (w_roff)
                OFF_SW:   w_rdata = DATA_WIDTH'(r_sync2);
                OFF_CHG:  w_rdata = DATA_WIDTH'(r_flag);
                OFF_STAT: w_rdata = DATA_WIDTH'(r_err);
                default:  w_rdata = '0;
            endcase
        end
    end

    // Registered read port, display registers, switch synchroniser, change flag and status
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalue    <= '0;
            r_rvalid    <= 1'b0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_prev <= '0;
            r_flag      <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < int'(NUM_DISP); i++) r_disp[i] <= '0;
        end else begin
            r_rvalid    <= w_racc;
            if (w_racc) r_rvalue <= w_rdata;
            r_sync1     <= switches;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            // Set wins over read-to-clear
            if (w_change) r_flag <= 1'b1;
            else if (w_racc && w_rmmio && w_roff == OFF_CHG) r_flag <= 1'b0;
            // Set wins over write-to-clear
            if ((w_racc && !w_rmapped) || (w_wacc && !w_wmapped)) r_err <= 1'b1;
            else if (w_wacc && w_wmmio && w_woff == OFF_STAT) r_err <= 1'b0;
            if (w_wacc && w_wdisp) r_disp[w_woff[DISP_AW-1:0]] <= wvalue;
        end
    end

    for (genvar g = 0; g < int'(NUM_DISP); g++) begin : g_disp
        assign disp_values[g*DATA_WIDTH +: DATA_WIDTH] = r_disp[g];
    end

    assign rvalue       = r_rvalue;
    assign rvalid       = r_rvalid;
    assign busy         = w_busy;
    assign access_error = r_err;
endmodule

// File: tb/tb_mapped_memory_controller.sv
// Scoreboard bench for mapped_memory_controller; clear-engine scenarios run when RAM_CLEAR_EN
// is defined.
module tb_mapped_memory_controller;
    localparam logic [15:0] BASE = 16'hFFF0;

    logic        clock = 1'b0;
    logic        reset_n, ren, wenable, rvalid, busy, access_error;
    logic [15:0] radr, wadr;
    logic [31:0] wvalue, rvalue;
    logic [63:0] disp_values;
    logic [17:0] switches;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    mapped_memory_controller dut (
        .clock(clock), .reset_n(reset_n), .ren(ren), .radr(radr), .rvalue(rvalue),
        .rvalid(rvalid), .wenable(wenable), .wadr(wadr), .wvalue(wvalue), .busy(busy),
        .disp_values(disp_values), .switches(switches), .access_error(access_error)
    );

    always #5 clock = ~clock;

    // Every rvalid must match the oldest outstanding expected read
    always @(negedge clock) begin
        if (rvalid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rvalid_spurious rvalue=%h with no read pending", rvalue);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (rvalue !== exp) begin
                    errors++;
                    $display("FAIL read_data got %h expected %h", rvalue, exp);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        wenable = 1'b1; wadr = a; wvalue = d;
        cycle();
        wenable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] exp);
        ren = 1'b1; radr = a; sb.push_back(exp);
        cycle();
        ren = 1'b0;
    endtask

    task automatic bus_rw(input logic [15:0] a, input logic [31:0] d);
        ren = 1'b1; radr = a; wenable = 1'b1; wadr = a; wvalue = d; sb.push_back(d);
        cycle();
        ren = 1'b0; wenable = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin cycle(); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin cycle(); n++; end
    endtask

    task automatic test_reset();
        int n;
        logic exp_busy;
`ifdef RAM_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        reset_n = 1'b0; ren = 1'b0; wenable = 1'b0; radr = '0; wadr = '0; wvalue = '0;
        switches = '0;
        repeat (3) cycle();
        checks++;
        if (rvalue !== 32'h0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_read rvalue=%h rvalid=%b expected 0/0", rvalue, rvalid);
        end
        checks++;
        if (disp_values !== 64'h0 || access_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs disp=%h err=%b expected 0/0", disp_values, access_error);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++; $display("FAIL reset_busy got %b expected %b", busy, exp_busy);
        end
        reset_n = 1'b1;
        wait_idle(n);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_timeout busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ram();
        logic [31:0] vals [4];
        bus_write(16'h0010, 32'hDEADBEEF);
        bus_read(16'h0010, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            bus_write(16'h0100 + 16'(i), vals[i]);
        end
        bus_write(16'h03FF, 32'hCAFE0001);
        for (int i = 0; i < 4; i++) bus_read(16'h0100 + 16'(i), vals[i]);
        bus_read(16'h03FF, 32'hCAFE0001);
        wait_drain();
    endtask

    task automatic test_forward();
        bus_rw(16'h0020, 32'h12345678);
        bus_read(16'h0020, 32'h12345678);
        wait_drain();
    endtask

    task automatic test_disp();
        bus_write(BASE + 16'd1, 32'h7);
        checks++;
        if (disp_values[63:32] !== 32'h7 || disp_values[31:0] !== 32'h0) begin
            errors++; $display("FAIL disp_write got %h expected 00000007_00000000", disp_values);
        end
        bus_read(BASE + 16'd1, 32'h7);
        bus_rw(BASE, 32'hA5A5_0000);
        bus_read(BASE, 32'hA5A5_0000);
        wait_drain();
        checks++;
        if (disp_values !== 64'h0000_0007_A5A5_0000) begin
            errors++; $display("FAIL disp_both got %h expected 00000007a5a50000", disp_values);
        end
    endtask

    task automatic test_switches();
        switches = 18'h2A5;
        cycle(); cycle();
        bus_read(BASE + 16'd8, 32'h2A5);
        bus_read(BASE + 16'd9, 32'h1);
        bus_read(BASE + 16'd9, 32'h0);
        // Change arrives at the edge that samples the flag read
        switches = 18'h2A4;
        cycle(); cycle();
        bus_read(BASE + 16'd9, 32'h0);
        bus_read(BASE + 16'd9, 32'h1);
        bus_read(BASE + 16'd9, 32'h0);
        bus_read(BASE + 16'd8, 32'h2A4);
        bus_write(BASE + 16'd8, 32'hFFFF);
        bus_read(BASE + 16'd8, 32'h2A4);
        wait_drain();
        checks++;
        if (access_error !== 1'b0) begin
            errors++; $display("FAIL switch_write_err got %b expected 0", access_error);
        end
    endtask

    task automatic test_error();
        bus_write(BASE + 16'd3, 32'h1);
        checks++;
        if (access_error !== 1'b1) begin
            errors++; $display("FAIL err_write_unmapped got %b expected 1", access_error);
        end
        bus_write(BASE + 16'd10, 32'h0);
        checks++;
        if (access_error !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b expected 0", access_error);
        end
        bus_read(16'h0400, 32'h0);
        bus_read(BASE + 16'd10, 32'h1);
        wait_drain();
        checks++;
        if (access_error !== 1'b1) begin
            errors++; $display("FAIL err_read_unmapped got %b expected 1", access_error);
        end
        // Clear and set in the same cycle: set wins
        ren = 1'b1; radr = BASE + 16'd12; sb.push_back(32'h0);
        wenable = 1'b1; wadr = BASE + 16'd10; wvalue = 32'h0;
        cycle();
        ren = 1'b0; wenable = 1'b0;
        checks++;
        if (access_error !== 1'b1) begin
            errors++; $display("FAIL err_set_wins got %b expected 1", access_error);
        end
        bus_write(BASE + 16'd10, 32'h0);
        bus_read(BASE + 16'd10, 32'h0);
        wait_drain();
    endtask

`ifdef RAM_CLEAR_EN
    task automatic test_clear();
        int n;
        sb.delete();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        // Requests during busy must be ignored
        wenable = 1'b1; wadr = BASE; wvalue = 32'hBAD0BAD0;
        ren = 1'b1; radr = 16'h0005;
        repeat (4) cycle();
        wadr = 16'h0800;
        repeat (4) cycle();
        wenable = 1'b0; ren = 1'b0;
        wait_idle(n);
        n = n + 8;
        checks++;
        if (n != 1024) begin
            errors++; $display("FAIL busy_length got %0d expected 1024", n);
        end
        checks++;
        if (disp_values !== 64'h0 || access_error !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignored disp=%h err=%b expected 0/0", disp_values, access_error);
        end
        bus_read(16'h03FF, 32'h0);
        bus_read(16'h0010, 32'h0);
        wait_drain();
        // Reset in the middle of the sweep restarts the full busy period
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        repeat (500) cycle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_in_reset got %b expected 1", busy);
        end
        cycle();
        reset_n = 1'b1;
        wait_idle(n);
        checks++;
        if (n != 1024) begin
            errors++; $display("FAIL busy_restart got %0d expected 1024", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_forward();
        test_disp();
        test_switches();
        test_error();
`ifdef RAM_CLEAR_EN
        test_clear();
`endif
        repeat (3) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
